// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard slice.
//   REG_FILE_ADDRESS_LEN : default register address width
//   SLOT_DEST_W          : storage width of a slot destination field; narrower
//                          addresses are zero-extended into it
//   slot_t               : one in-flight writer {valid, dest, is_load}
//   FWD_SEL_RF / FWD_SEL_SLOT_BASE : fwd_sel encoding (0 = register file,
//                          slot k is reported as k + FWD_SEL_SLOT_BASE)
`ifndef REG_FILE_ADDRESS_LEN
`define REG_FILE_ADDRESS_LEN 4
`endif

package hazard_scoreboard_pkg;

  localparam int unsigned REG_FILE_ADDRESS_LEN = `REG_FILE_ADDRESS_LEN;

  // Upper bound on ADDR_W supported by the slot storage.
  localparam int unsigned SLOT_DEST_W = 16;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_DEST_W-1:0] dest;
    logic                   is_load;
  } slot_t;

  localparam int unsigned FWD_SEL_RF        = 0;
  localparam int unsigned FWD_SEL_SLOT_BASE = 1;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: compares one ID source register against every in-flight
// writer slot and reports the youngest (lowest index) match.
//   id_valid_i : instruction present in ID
//   use_i      : this source is actually read by the instruction
//   src_i      : source register address
//   slots_i    : writer slots, index 0 is the youngest
//   hit_o      : some slot matches
//   idx_o      : index of the youngest matching slot (0 when no hit)
//   is_load_o  : is_load flag of that slot (0 when no hit)
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_FILE_ADDRESS_LEN,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic                    id_valid_i,
  input  logic                    use_i,
  input  logic [ADDR_W-1:0]       src_i,
  input  slot_t [DEPTH-1:0]       slots_i,
  output logic                    hit_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    is_load_o
);

  logic [SLOT_DEST_W-1:0] src_ext;
  logic                   found;

  assign src_ext = SLOT_DEST_W'(src_i);

  // Ascending scan; the first hit latches, so the youngest slot wins.
  always_comb begin
    found     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && id_valid_i && use_i && slots_i[i].valid &&
          (slots_i[i].dest == src_ext)) begin
        found     = 1'b1;
        idx_o     = IDX_W'(i);
        is_load_o = slots_i[i].is_load;
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks DEPTH in-flight register writers between ID and
// WB and raises a stall (hazard) for read-after-write dependencies.
// Optional macro FORWARDING_EN: when defined, matches are resolved by
// forwarding (fwd_sel1/2) and only a load in slot 0 stalls; otherwise any
// match stalls and fwd_sel1/2 stay 0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   id_valid, src1, src2, two_src, id_wb_en, id_dest, id_mem_read : ID stage
//   freeze                : memory-wait hold (overrides flush)
//   flush                 : branch-taken squash
//   hazard                : stall ID/IF, inject bubble
//   fwd_sel1, fwd_sel2    : forwarding source per operand
//   stall_cnt             : saturating count of stall cycles
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_FILE_ADDRESS_LEN,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [ADDR_W-1:0]          src1,
  input  logic [ADDR_W-1:0]          src2,
  input  logic                       two_src,
  input  logic                       id_wb_en,
  input  logic [ADDR_W-1:0]          id_dest,
  input  logic                       id_mem_read,
  input  logic                       freeze,
  input  logic                       flush,
  output logic                       hazard,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel2,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slot_t [DEPTH-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic             hit1, hit2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             ld1, ld2;

  hazard_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_match_src1 (
    .id_valid_i (id_valid),
    .use_i      (1'b1),
    .src_i      (src1),
    .slots_i    (slots_q),
    .hit_o      (hit1),
    .idx_o      (idx1),
    .is_load_o  (ld1)
  );

  hazard_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_match_src2 (
    .id_valid_i (id_valid),
    .use_i      (two_src),
    .src_i      (src2),
    .slots_i    (slots_q),
    .hit_o      (hit2),
    .idx_o      (idx2),
    .is_load_o  (ld2)
  );

`ifdef FORWARDING_EN
  // Only a load still in EXE (slot 0) cannot be forwarded in time.
  always_comb begin
    hazard   = (hit1 && (idx1 == '0) && ld1) || (hit2 && (idx2 == '0) && ld2);
    fwd_sel1 = SEL_W'(FWD_SEL_RF);
    fwd_sel2 = SEL_W'(FWD_SEL_RF);
    if (!hazard && hit1) fwd_sel1 = SEL_W'(FWD_SEL_SLOT_BASE) + SEL_W'(idx1);
    if (!hazard && hit2) fwd_sel2 = SEL_W'(FWD_SEL_SLOT_BASE) + SEL_W'(idx2);
  end
`else
  logic unused_match_info;
  assign unused_match_info = ^{idx1, idx2, ld1, ld2};

  always_comb begin
    hazard   = hit1 || hit2;
    fwd_sel1 = SEL_W'(FWD_SEL_RF);
    fwd_sel2 = SEL_W'(FWD_SEL_RF);
  end
`endif

  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) slots_d[i].valid = 1'b0;
      end else begin
        // A stalled instruction enters as a bubble.
        slots_d[0].valid   = id_valid && id_wb_en && !hazard;
        slots_d[0].dest    = SLOT_DEST_W'(id_dest);
        slots_d[0].is_load = id_mem_read;
        for (int unsigned i = 1; i < DEPTH; i++) slots_d[i] = slots_q[i-1];
      end
      if (hazard && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] src1, src2;
  logic       two_src;
  logic       id_wb_en;
  logic [3:0] id_dest;
  logic       id_mem_read;
  logic       freeze, flush;
  logic       hazard;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [3:0] stall_cnt;

  int n_checks = 0;
  int n_passed = 0;
  int exp_cnt  = 0;

`ifdef FORWARDING_EN
  localparam int STALLS_PER_LOAD_USE = 1;
`else
  localparam int STALLS_PER_LOAD_USE = 2;
`endif

  hazard_scoreboard #(
    .ADDR_W (4),
    .DEPTH  (2),
    .CNT_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .id_mem_read (id_mem_read),
    .freeze      (freeze),
    .flush       (flush),
    .hazard      (hazard),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    src1        = '0;
    src2        = '0;
    two_src     = 1'b0;
    id_wb_en    = 1'b0;
    id_dest     = '0;
    id_mem_read = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                       input logic wb, input logic [3:0] dst, input logic ld);
    id_valid    = 1'b1;
    src1        = s1;
    src2        = s2;
    two_src     = two;
    id_wb_en    = wb;
    id_dest     = dst;
    id_mem_read = ld;
    #1;
  endtask

  task automatic bump(input int n);
    exp_cnt = (exp_cnt + n > 15) ? 15 : exp_cnt + n;
  endtask

  // Load to R7 followed by a dependent reader, held until it may issue.
  task automatic load_use_pair();
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1);
    tick();
    issue(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < STALLS_PER_LOAD_USE; i++) tick();
    bump(STALLS_PER_LOAD_USE);
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_hazard", hazard, 0);
    check("rst_fwd1", fwd_sel1, 0);
    check("rst_fwd2", fwd_sel2, 0);
    check("rst_cnt", stall_cnt, 0);

    // ALU writer R3, then reader of R3 on src1
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
    check("a_writer_haz", hazard, 0);
    tick();
    issue(4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
`ifdef FORWARDING_EN
    check("a_rd_haz", hazard, 0);
    check("a_rd_fwd1", fwd_sel1, 1);
    tick();
`else
    check("a_rd_haz0", hazard, 1);
    check("a_rd_fwd1", fwd_sel1, 0);
    tick(); bump(1);
    check("a_rd_haz1", hazard, 1);
    tick(); bump(1);
    check("a_rd_haz2", hazard, 0);
    tick();
`endif
    check("a_cnt", stall_cnt, exp_cnt);
    idle(); tick(); tick();

    // ALU writer R5, reader on src2 with two_src
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
    tick();
    issue(4'd1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
`ifdef FORWARDING_EN
    check("b_haz0", hazard, 0);
    check("b_fwd2_exe", fwd_sel2, 1);
    check("b_fwd1_rf", fwd_sel1, 0);
    tick();
    check("b_fwd2_mem", fwd_sel2, 2);
    tick();
`else
    check("b_haz0", hazard, 1);
    check("b_fwd2", fwd_sel2, 0);
    tick(); bump(1);
    check("b_haz1", hazard, 1);
    tick(); bump(1);
`endif
    idle(); tick(); tick();
    check("b_cnt", stall_cnt, exp_cnt);

    // load R7, reader of R7
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1);
    tick();
    issue(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("c_haz0", hazard, 1);
    check("c_fwd1_stall", fwd_sel1, 0);
    tick(); bump(1);
`ifdef FORWARDING_EN
    check("c_haz1", hazard, 0);
    check("c_fwd1_mem", fwd_sel1, 2);
`else
    check("c_haz1", hazard, 1);
    tick(); bump(1);
    check("c_haz2", hazard, 0);
`endif
    tick();
    idle(); tick(); tick();
    check("c_cnt", stall_cnt, exp_cnt);

    // Stall held by a load in slot 0 through freeze, then flushed
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b1);
    tick();
    issue(4'd9, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("d_haz", hazard, 1);
    freeze = 1'b1;
    tick();
    check("d_frz1_haz", hazard, 1);
    check("d_frz1_cnt", stall_cnt, exp_cnt);
    flush = 1'b1;
    tick();
    check("d_frz_flush_haz", hazard, 1);
    check("d_frz_flush_cnt", stall_cnt, exp_cnt);
    flush = 1'b0;
    tick();
    check("d_frz3_haz", hazard, 1);
    check("d_frz3_cnt", stall_cnt, exp_cnt);
    freeze = 1'b0; flush = 1'b1;
    tick(); bump(1);
    flush = 1'b0;
    #1;
    check("d_flushed_haz", hazard, 0);
    check("d_flushed_cnt", stall_cnt, exp_cnt);
    idle(); tick();

    // Two writers of R4: youngest wins
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
    tick();
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
    tick();
    issue(4'd4, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
`ifdef FORWARDING_EN
    check("g_haz", hazard, 0);
    check("g_fwd1_young", fwd_sel1, 1);
    tick();
`else
    check("g_haz0", hazard, 1);
    tick(); bump(1);
    check("g_haz1", hazard, 1);
    tick(); bump(1);
`endif
    idle(); tick(); tick();

    // two_src=0 with src2 matching
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    issue(4'd0, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0);
    check("e_haz", hazard, 0);
    check("e_fwd2", fwd_sel2, 0);
    tick();
    idle(); tick(); tick();
    check("e_cnt", stall_cnt, exp_cnt);

    // Saturation
    for (int k = 0; k < 16 && exp_cnt < 15; k++) load_use_pair();
    check("sat_reach", stall_cnt, 15);
    load_use_pair();
    check("sat_hold", stall_cnt, 15);

    // Reset asserted mid-stall
    issue(4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b1);
    tick();
    issue(4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("r_haz_pre", hazard, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("r_haz_post", hazard, 0);
    check("r_fwd1_post", fwd_sel1, 0);
    check("r_cnt_post", stall_cnt, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default `REG_FILE_ADDRESS_LEN (4): register address width.
REQ-002 SHALL have parameter DEPTH, default 2: number of in-flight writer slots tracked between ID and WB (slot 0 = EXE, slot 1 = MEM, ...); legal range 1..8.
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-004 SHALL have the following ports:
- clk  in  1: the single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- id_valid  in  1: an instruction is present in ID.
- src1  in  ADDR_W: ID source register 1.
- src2  in  ADDR_W: ID source register 2.
- two_src  in  1: src2 is used.
- id_wb_en  in  1: the ID instruction writes a register.
- id_dest  in  ADDR_W: ID destination register.
- id_mem_read  in  1: the ID instruction is a load.
- freeze  in  1: memory-wait pipeline hold.
- flush  in  1: branch-taken squash.
- hazard  out  1: stall ID/IF and inject a bubble.
- fwd_sel1  out  $clog2(DEPTH+1): src1 forwarding source (0 = register file, k = slot k-1).
- fwd_sel2  out  $clog2(DEPTH+1): src2 forwarding source (same encoding as fwd_sel1).
- stall_cnt  out  CNT_W: number of stall cycles counted.

Function
REQ-005 SHALL hold DEPTH slots, each {valid, dest, is_load}, as a shift register.
REQ-006 SHALL, on an edge with freeze=0 and flush=0, load slot0 <= {id_valid & id_wb_en & ~hazard, id_dest, id_mem_read} and slot[i] <= slot[i-1]; the oldest slot is discarded.
REQ-007 SHALL, on an edge with flush=1 and freeze=0, clear valid in every slot.
REQ-008 SHALL hold all slots unchanged on an edge with freeze=1; freeze overrides flush.
REQ-009 SHALL define src1 match[i] = id_valid & slot[i].valid & (src1 == slot[i].dest).
REQ-010 SHALL define src2 match[i] = the src1 condition using src2, additionally ANDed with two_src.
REQ-011 SHALL treat no register address as exempt from matching.
REQ-012 SHALL resolve multiple matches for one source to the youngest slot, i.e. the lowest index.
REQ-013 SHALL compute hazard and fwd_sel1/2 combinationally from the current slot state and ID inputs, with zero-cycle latency.
REQ-014 SHALL, without forwarding, drive hazard=1 iff either source matches any slot.
REQ-015 SHALL increment stall_cnt on an edge with hazard=1 and freeze=0.
REQ-016 SHALL saturate stall_cnt at all-ones.
REQ-017 SHALL clear stall_cnt only by rst.
REQ-018 SHALL treat a stalled ID instruction as a bubble, so that it is never entered into slot0 (REQ-006); the instruction re-evaluates every cycle until hazard=0.

Reset
REQ-019 SHALL, on rst=1 at an edge, clear all slot valid bits and stall_cnt, regardless of freeze and flush.
REQ-020 SHALL therefore drive hazard=0, fwd_sel1=0 and fwd_sel2=0 in the cycle after reset.
REQ-021 SHALL discard the tracked state when reset is asserted mid-stall, with no residual hazard.

Configuration
REQ-022 SHALL compile forwarding in only when macro FORWARDING_EN is defined.
REQ-023 SHALL, with FORWARDING_EN defined, drive hazard=1 only when the youngest match for a used source is slot0 with is_load=1 (load-use).
REQ-024 SHALL, with FORWARDING_EN defined, drive fwd_selN = youngest matching slot index + 1, or 0 when there is no match or hazard=1.
REQ-025 SHALL, without FORWARDING_EN, tie fwd_sel1 and fwd_sel2 to 0 and apply REQ-014.

Structure
REQ-026 SHALL place the slot struct typedef and the fwd_sel encoding constants in the shared defines package, alongside REG_FILE_ADDRESS_LEN.
REQ-027 SHALL implement per-source match and youngest-priority selection in one sub-module, hazard_match, instantiated twice (src1, src2).

Verification
REQ-028 SHALL be verified by a bench covering at least the following scenarios, all with DEPTH=2:
- Reset: rst high for 2 cycles -> hazard=0, fwd_sel=0, stall_cnt=0.
- No forwarding: issue a writer of R3, then the next instruction reads src1=R3 -> hazard=1 for 2 cycles, then 0; stall_cnt=2.
- FORWARDING_EN: ALU writer of R5 followed by a reader with src2=R5 and two_src=1 -> hazard=0, fwd_sel2=1; one cycle later fwd_sel2=2.
- FORWARDING_EN load-use: load to R7 followed by a reader of R7 -> hazard=1 for exactly 1 cycle, then fwd_sel1=2.
- Freeze during a stall: freeze=1 for 3 cycles -> slots frozen, hazard held, stall_cnt unchanged; flush=1 with freeze=0 -> all slots clear, hazard=0 next cycle.
- two_src=0 with src2 matching a slot -> hazard=0 and fwd_sel2=0; counter at all-ones with a further stall -> stays all-ones.
